// File: rtl/bht_ctrl.sv
// Branch history / target controller: direct-mapped table of 2-bit direction counters
// and targets, combinational next-PC prediction, execute-stage update, redirect and statistics.
module bht_ctrl #(
   parameter int IDX_W = 6,
   parameter int TAG_W = 24 - IDX_W,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pcen,
   input  logic [31:0]      fetch_pc,
   output logic             pred_taken,
   output logic [31:0]      pred_npc,
   input  logic             upd_valid,
   input  logic [31:0]      upd_pc,
   input  logic             upd_taken,
   input  logic [31:0]      upd_target,
   input  logic             upd_pred_taken,
   input  logic [31:0]      upd_pred_npc,
   output logic             redirect,
   output logic [31:0]      redirect_pc,
   input  logic             stat_clr,
   output logic [CNT_W-1:0] lkp_cnt,
   output logic [CNT_W-1:0] hit_cnt,
   output logic [CNT_W-1:0] mis_cnt
);
   localparam int DEPTH  = 1 << IDX_W;
   localparam int TAG_LO = IDX_W + 2;
   localparam int TAG_HI = TAG_W + IDX_W + 1;

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      logic [1:0]       ctr;
      logic [31:0]      target;
   } entry_t;

   entry_t tbl [DEPTH];

   logic [IDX_W-1:0] f_idx, u_idx;
   logic [TAG_W-1:0] f_tag, u_tag;
   entry_t           f_ent, u_ent, u_new;
   logic             f_hit, u_hit, u_wr, upd_en, mispred;
   logic             unused_bits;

   // Lookup path: purely combinational off the current table contents
   assign f_idx      = fetch_pc[IDX_W+1:2];
   assign f_tag      = fetch_pc[TAG_HI:TAG_LO];
   assign f_ent      = tbl[f_idx];
   assign f_hit      = f_ent.valid && (f_ent.tag == f_tag);
   assign pred_taken = f_hit && f_ent.ctr[1];
   assign pred_npc   = pred_taken ? f_ent.target : fetch_pc + 32'd4;

   assign upd_en      = upd_valid && pcen;
   assign mispred     = (upd_taken != upd_pred_taken) ||
                        (upd_taken && (upd_target != upd_pred_npc));
   assign redirect    = upd_en && mispred;
   assign redirect_pc = upd_taken ? upd_target : upd_pc + 32'd4;

   assign u_idx = upd_pc[IDX_W+1:2];
   assign u_tag = upd_pc[TAG_HI:TAG_LO];
   assign u_ent = tbl[u_idx];
   assign u_hit = u_ent.valid && (u_ent.tag == u_tag);

   assign unused_bits = ^{fetch_pc[1:0], fetch_pc[31:TAG_HI+1],
                          upd_pc[1:0], upd_pc[31:TAG_HI+1], f_ent.ctr[0]};

   always_comb begin
      u_new = u_ent;
      u_wr  = 1'b0;
      if (upd_en) begin
         if (u_hit) begin
            u_wr = 1'b1;
            if (upd_taken) begin
               if (u_ent.ctr != 2'b11) u_new.ctr = u_ent.ctr + 2'd1;
               u_new.target = upd_target;
            end else if (u_ent.ctr != 2'b00) begin
               u_new.ctr = u_ent.ctr - 2'd1;
            end
         end else if (upd_taken) begin
            // Taken miss allocates over whatever alias held the slot, weakly taken
            u_wr  = 1'b1;
            u_new = '{valid: 1'b1, tag: u_tag, ctr: 2'b10, target: upd_target};
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++)
            tbl[i] <= '{valid: 1'b0, tag: '0, ctr: 2'b01, target: '0};
      end else if (u_wr) begin
         tbl[u_idx] <= u_new;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lkp_cnt <= '0;
         hit_cnt <= '0;
         mis_cnt <= '0;
      end else if (stat_clr) begin
         lkp_cnt <= '0;
         hit_cnt <= '0;
         mis_cnt <= '0;
      end else if (pcen) begin
         lkp_cnt <= lkp_cnt + CNT_W'(1);
         if (f_hit)    hit_cnt <= hit_cnt + CNT_W'(1);
         if (redirect) mis_cnt <= mis_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_bht_ctrl.sv
// Bench for bht_ctrl: directed vector table, counter wrap, randomized traffic against
// an array-based reference model, and asynchronous mid-cycle reset.
module tb_bht_ctrl;
   logic        clk = 1'b0;
   logic        rst, pcen, upd_valid, upd_taken, upd_pred_taken, stat_clr;
   logic [31:0] fetch_pc, upd_pc, upd_target, upd_pred_npc;
   logic        pred_taken, redirect;
   logic [31:0] pred_npc, redirect_pc;
   logic [15:0] lkp_cnt, hit_cnt, mis_cnt;

   always #5 clk = ~clk;

   bht_ctrl dut (
      .clk(clk), .rst(rst), .pcen(pcen), .fetch_pc(fetch_pc),
      .pred_taken(pred_taken), .pred_npc(pred_npc),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
      .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
      .upd_pred_npc(upd_pred_npc), .redirect(redirect), .redirect_pc(redirect_pc),
      .stat_clr(stat_clr), .lkp_cnt(lkp_cnt), .hit_cnt(hit_cnt), .mis_cnt(mis_cnt)
   );

   int n_chk = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: table kept as plain arrays, index/tag by arithmetic on the PC
   bit          m_valid [64];
   int unsigned m_tag   [64];
   int          m_ctr   [64];
   logic [31:0] m_tgt   [64];
   int unsigned m_lkp, m_hit, m_mis;

   function automatic int ix(input logic [31:0] pc);
      return int'((pc / 4) % 64);
   endfunction
   function automatic int unsigned tg(input logic [31:0] pc);
      return (pc / 256) % (1 << 18);
   endfunction
   function automatic void model_reset();
      for (int i = 0; i < 64; i++) begin
         m_valid[i] = 0; m_tag[i] = 0; m_ctr[i] = 1; m_tgt[i] = '0;
      end
      m_lkp = 0; m_hit = 0; m_mis = 0;
   endfunction
   function automatic bit m_hitf(input logic [31:0] pc);
      return m_valid[ix(pc)] && (m_tag[ix(pc)] == tg(pc));
   endfunction
   function automatic bit m_pt(input logic [31:0] pc);
      return m_hitf(pc) && (m_ctr[ix(pc)] >= 2);
   endfunction
   function automatic logic [31:0] m_npc(input logic [31:0] pc);
      return m_pt(pc) ? m_tgt[ix(pc)] : pc + 32'd4;
   endfunction
   function automatic bit m_misp();
      return pcen && upd_valid &&
             ((upd_taken != upd_pred_taken) || (upd_taken && upd_target != upd_pred_npc));
   endfunction
   function automatic void model_step();
      bit h, mp;
      int i;
      h = m_hitf(fetch_pc);
      mp = m_misp();
      i = ix(upd_pc);
      if (stat_clr) begin
         m_lkp = 0; m_hit = 0; m_mis = 0;
      end else if (pcen) begin
         m_lkp = (m_lkp + 1) % 65536;
         if (h)  m_hit = (m_hit + 1) % 65536;
         if (mp) m_mis = (m_mis + 1) % 65536;
      end
      if (pcen && upd_valid) begin
         if (m_hitf(upd_pc)) begin
            if (upd_taken) begin
               m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
               m_tgt[i] = upd_target;
            end else begin
               m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
            end
         end else if (upd_taken) begin
            m_valid[i] = 1; m_tag[i] = tg(upd_pc); m_ctr[i] = 2; m_tgt[i] = upd_target;
         end
      end
   endfunction

   // Called right after inputs are driven in the low phase; returns at the next negedge
   task automatic run_cycle(input string nm);
      #2;
      check({nm, ".pred_taken"},  32'(pred_taken), 32'(m_pt(fetch_pc)));
      check({nm, ".pred_npc"},    pred_npc, m_npc(fetch_pc));
      check({nm, ".redirect"},    32'(redirect), 32'(m_misp()));
      check({nm, ".redirect_pc"}, redirect_pc, upd_taken ? upd_target : upd_pc + 32'd4);
      @(posedge clk);
      model_step();
      #1;
      check({nm, ".lkp_cnt"}, 32'(lkp_cnt), m_lkp);
      check({nm, ".hit_cnt"}, 32'(hit_cnt), m_hit);
      check({nm, ".mis_cnt"}, 32'(mis_cnt), m_mis);
      @(negedge clk);
   endtask

   typedef struct {
      logic [31:0] fpc;
      logic        pcen, uv;
      logic [31:0] upc;
      logic        tk;
      logic [31:0] tgt;
      logic        ppt;
      logic [31:0] pnpc;
      logic        ept;
      logic [31:0] enpc;
      logic        erd;
      logic [31:0] erpc;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t mk(input logic [31:0] fpc, input logic pe, input logic uv,
                               input logic [31:0] upc, input logic tk, input logic [31:0] tgt,
                               input logic ppt, input logic [31:0] pnpc, input logic ept,
                               input logic [31:0] enpc, input logic erd, input logic [31:0] erpc);
      vec_t v;
      v.fpc = fpc; v.pcen = pe; v.uv = uv; v.upc = upc; v.tk = tk; v.tgt = tgt;
      v.ppt = ppt; v.pnpc = pnpc; v.ept = ept; v.enpc = enpc; v.erd = erd; v.erpc = erpc;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      fetch_pc = v.fpc; pcen = v.pcen; upd_valid = v.uv; upd_pc = v.upc;
      upd_taken = v.tk; upd_target = v.tgt; upd_pred_taken = v.ppt;
      upd_pred_npc = v.pnpc; stat_clr = 1'b0;
   endtask

   initial begin
      vec_t v;
      // fetch pcen uv upd_pc tk target ppt pnpc | pt npc rd rpc
      vt.push_back(mk(32'h3000,1,0,32'h3000,0,32'h0   ,0,32'h0   , 0,32'h3004,0,32'h3004));
      vt.push_back(mk(32'h3000,1,1,32'h3010,1,32'h3040,0,32'h3014, 0,32'h3004,1,32'h3040));
      vt.push_back(mk(32'h3010,1,0,32'h3010,0,32'h0   ,0,32'h0   , 1,32'h3040,0,32'h3014));
      vt.push_back(mk(32'h3010,1,1,32'h3010,0,32'h0   ,1,32'h3040, 1,32'h3040,1,32'h3014));
      vt.push_back(mk(32'h3010,1,1,32'h3010,0,32'h0   ,0,32'h3014, 0,32'h3014,0,32'h3014));
      vt.push_back(mk(32'h3010,1,1,32'h3010,1,32'h3040,0,32'h3014, 0,32'h3014,1,32'h3040));
      vt.push_back(mk(32'h3010,1,0,32'h3010,0,32'h0   ,0,32'h0   , 0,32'h3014,0,32'h3014));
      vt.push_back(mk(32'h3020,1,1,32'h3020,0,32'h0   ,0,32'h3024, 0,32'h3024,0,32'h3024));
      vt.push_back(mk(32'h3020,1,0,32'h3020,0,32'h0   ,0,32'h0   , 0,32'h3024,0,32'h3024));
      vt.push_back(mk(32'h3020,0,1,32'h3020,1,32'h3100,0,32'h3024, 0,32'h3024,0,32'h3100));
      vt.push_back(mk(32'h3020,1,0,32'h3020,0,32'h0   ,0,32'h0   , 0,32'h3024,0,32'h3024));
      vt.push_back(mk(32'h3010,1,1,32'h3010,1,32'h3080,1,32'h3040, 0,32'h3014,1,32'h3080));
      vt.push_back(mk(32'h3010,1,0,32'h3010,0,32'h0   ,0,32'h0   , 1,32'h3080,0,32'h3014));
      vt.push_back(mk(32'h3010,1,1,32'h3010,1,32'h3080,1,32'h3080, 1,32'h3080,0,32'h3080));
      vt.push_back(mk(32'h3010,1,1,32'h3010,1,32'h3080,1,32'h3080, 1,32'h3080,0,32'h3080));
      vt.push_back(mk(32'h3010,1,1,32'h3010,0,32'h0   ,1,32'h3080, 1,32'h3080,1,32'h3014));
      vt.push_back(mk(32'h3010,1,0,32'h3010,0,32'h0   ,0,32'h0   , 1,32'h3080,0,32'h3014));
      vt.push_back(mk(32'h3010,1,1,32'h3110,1,32'h3200,0,32'h3114, 1,32'h3080,1,32'h3200));
      vt.push_back(mk(32'h3010,1,0,32'h3010,0,32'h0   ,0,32'h0   , 0,32'h3014,0,32'h3014));
      vt.push_back(mk(32'h3110,1,0,32'h3110,0,32'h0   ,0,32'h0   , 1,32'h3200,0,32'h3114));

      // Reset state, held with rst asserted
      rst = 1'b1;
      drive(vt[0]);
      model_reset();
      #3;
      check("rst.pred_taken", 32'(pred_taken), 32'h0);
      check("rst.pred_npc", pred_npc, 32'h3004);
      check("rst.lkp_cnt", 32'(lkp_cnt), 32'h0);
      check("rst.hit_cnt", 32'(hit_cnt), 32'h0);
      check("rst.mis_cnt", 32'(mis_cnt), 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // Directed vectors
      for (int k = 0; k < vt.size(); k++) begin
         v = vt[k];
         drive(v);
         #1;
         check($sformatf("vec%0d.pred_taken", k), 32'(pred_taken), 32'(v.ept));
         check($sformatf("vec%0d.pred_npc", k), pred_npc, v.enpc);
         check($sformatf("vec%0d.redirect", k), 32'(redirect), 32'(v.erd));
         check($sformatf("vec%0d.redirect_pc", k), redirect_pc, v.erpc);
         #1;
         run_cycle($sformatf("vecm%0d", k));
         if (k == 1) check("vec1.mis_cnt", 32'(mis_cnt), 32'h1);
      end
      check("vec.lkp_total", 32'(lkp_cnt), 32'd19);
      check("vec.hit_total", 32'(hit_cnt), 32'd13);
      check("vec.mis_total", 32'(mis_cnt), 32'd6);

      // Synchronous stat clear beats a same-cycle mispredict increment
      drive(mk(32'h3110,1,1,32'h3010,0,32'h0,1,32'h3040, 0,0,0,0));
      stat_clr = 1'b1;
      run_cycle("statclr");
      check("statclr.lkp_cnt", 32'(lkp_cnt), 32'h0);
      check("statclr.mis_cnt", 32'(mis_cnt), 32'h0);

      // Lookup counter wrap
      drive(mk(32'h3020,1,0,32'h3020,0,32'h0,0,32'h0, 0,0,0,0));
      for (int n = 0; n < 65535; n++) begin
         @(posedge clk);
         model_step();
      end
      #1;
      check("wrap.lkp_ffff", 32'(lkp_cnt), 32'hFFFF);
      @(negedge clk);
      run_cycle("wrap");
      check("wrap.lkp_zero", 32'(lkp_cnt), 32'h0);

      // Randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         fetch_pc   = 32'h3000 + ($urandom_range(0, 31) << 2) + ($urandom_range(0, 1) << 8);
         upd_pc     = 32'h3000 + ($urandom_range(0, 31) << 2) + ($urandom_range(0, 1) << 8);
         upd_valid  = $urandom_range(0, 3) != 0;
         upd_taken  = $urandom_range(0, 1) == 1;
         upd_target = 32'h4000 + ($urandom_range(0, 15) << 2);
         if ($urandom_range(0, 3) != 0) begin
            upd_pred_taken = m_pt(upd_pc);
            upd_pred_npc   = m_npc(upd_pc);
         end else begin
            upd_pred_taken = $urandom_range(0, 1) == 1;
            upd_pred_npc   = 32'h4000 + ($urandom_range(0, 15) << 2);
         end
         pcen     = $urandom_range(0, 9) != 0;
         stat_clr = $urandom_range(0, 49) == 0;
         run_cycle("rand");
      end

      // Asynchronous reset between edges
      drive(mk(32'h5000,1,1,32'h5000,1,32'h5400,0,32'h5004, 0,0,0,0));
      run_cycle("pre_rst");
      upd_valid = 1'b0;
      #2;
      check("pre_rst.pred_taken", 32'(pred_taken), 32'h1);
      check("pre_rst.pred_npc", pred_npc, 32'h5400);
      rst = 1'b1;
      #1;
      check("async_rst.pred_taken", 32'(pred_taken), 32'h0);
      check("async_rst.pred_npc", pred_npc, 32'h5004);
      check("async_rst.lkp_cnt", 32'(lkp_cnt), 32'h0);
      check("async_rst.hit_cnt", 32'(hit_cnt), 32'h0);
      check("async_rst.mis_cnt", 32'(mis_cnt), 32'h0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      drive(mk(32'h5000,1,1,32'h5000,0,32'h0,0,32'h5004, 0,0,0,0));
      run_cycle("post_rst_upd");
      drive(mk(32'h5000,1,0,32'h5000,0,32'h0,0,32'h0, 0,0,0,0));
      #1;
      check("post_rst.pred_taken", 32'(pred_taken), 32'h0);
      #1;
      run_cycle("post_rst_lkp");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/bht_ctrl.md
# bht_ctrl

Branch history / target controller for the redirect pipeline's fetch stage. It holds a direct-mapped table of 2-bit saturating direction counters and branch targets, supplies the predicted next PC to fetch each cycle, and is updated when the next-PC unit resolves a branch in execute. On a misprediction it raises a redirect with the corrected PC. It also keeps wrapping 16-bit lookup, hit and mispredict statistics counters alongside the existing branch counters.

## Interface
- IDX_W, 6, index width; table depth = 2^IDX_W entries, indexed by pc[IDX_W+1:2]
- TAG_W, 24 - IDX_W, tag width, taken from pc[TAG_W+IDX_W+1:IDX_W+2]
- CNT_W, 16, statistics counter width

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; **asynchronous, active-high**
- pcen  in  1  pipeline advance enable; 0 = stall, nothing updates or counts
- fetch_pc  in  32  PC being fetched this cycle
- pred_taken  out  1  combinational: table hit and counter[1]==1
- pred_npc  out  32  combinational: pred_taken ? stored target : fetch_pc+4
- upd_valid  in  1  execute stage holds a resolved conditional branch or jump
- upd_pc  in  32  PC of the resolved instruction
- upd_taken  in  1  actual outcome
- upd_target  in  32  actual target when taken
- upd_pred_taken  in  1  prediction carried down the pipe with that instruction
- upd_pred_npc  in  32  predicted next PC carried down the pipe
- redirect  out  1  combinational mispredict flag (to pcclear / IF-ID flush)
- redirect_pc  out  32  corrected PC: upd_taken ? upd_target : upd_pc+4
- stat_clr  in  1  synchronous clear of the three statistics counters
- lkp_cnt  out  CNT_W  number of advancing fetch lookups
- hit_cnt  out  CNT_W  number of lookups that hit a valid tag
- mis_cnt  out  CNT_W  number of mispredicts

## Operation
- Entry = {valid, tag[TAG_W], ctr[2], target[32]}. Lookup hit = valid && tag match on fetch_pc.
- Reset: all valid=0, all ctr=2'b01, tag/target=0, lkp/hit/mis=0. Outputs under reset: pred_taken=0, pred_npc=fetch_pc+4.
- Mispredict (when upd_valid && pcen): (upd_taken != upd_pred_taken) or (upd_taken && upd_target != upd_pred_npc). redirect=1 only in that case; otherwise 0. redirect_pc driven always.
- Update (clock edge, upd_valid && pcen), index/tag from upd_pc:
  - hit: ctr +1 if taken (saturate at 2'b11), -1 if not taken (saturate at 2'b00); target <= upd_target if taken, else unchanged.
  - miss, taken: allocate/overwrite: valid=1, tag, target=upd_target, ctr=2'b10.
  - miss, not taken: no write.
- Statistics (clock edge): stat_clr=1 → all three to 0, overrides increments. Else, if pcen: lkp_cnt+1; hit_cnt+1 if lookup hit; mis_cnt+1 if mispredict. All wrap 0xFFFF→0x0000.
- pcen=0: table and counters hold; redirect forced 0.

## Timing
- Lookup is zero-latency combinational from fetch_pc and current table state.
- Update written at the edge ending the cycle upd_valid && pcen is seen; visible to lookups the following cycle.
- Same-cycle lookup and update on the same index: lookup returns pre-update contents.
- redirect is same-cycle as the resolving upd_*; the fetch PC mux takes redirect_pc at the next edge with priority over pred_npc.
- Reset asserted mid-operation clears table and counters immediately, independent of clk; the first update after release sees an empty table.
- Alias: two branches with equal index, different tag evict each other; no partial-tag behaviour.

## Test plan
- Reset, fetch_pc=0x00003000 → pred_taken=0, pred_npc=0x00003004, all counts 0.
- Update upd_pc=0x00003010, taken, target 0x00003040, upd_pred_taken=0 → redirect=1, redirect_pc=0x00003040, mis_cnt=1; next cycle fetch_pc=0x00003010 → pred_taken=1, pred_npc=0x00003040, hit_cnt increments.
- Same branch not-taken twice: ctr 10→01→00; after first, pred_taken=0; third taken update brings ctr to 01, still pred_taken=0.
- Update not-taken at miss 0x00003020 with upd_pred_taken=0 → no allocation, redirect=0; lookup still misses.
- Hold pcen=0 with upd_valid=1 mispredicting → redirect=0, table and counters unchanged; stat_clr with pcen=1 → counts 0 next cycle.
- Preload lkp_cnt to 0xFFFF via 65535 advancing cycles; one more → 0x0000. Assert rst mid-run between edges → outputs reset without a clock edge.
